// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// The strict-alternation option is selected with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

    localparam int unsigned MEM_LAT_MAX = 15;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_PORT_IF = 1'b0,
        ARB_PORT_D  = 1'b1
    } arb_port_e;

    // True when a read latency fits the wait counter and is non-zero.
    function automatic logic lat_legal(input int unsigned lat);
        return (lat >= 1) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data requesters.
// Default: data port always wins a tie. With MEM_ARB_RR_EN defined, a tie
// goes to the port that did not win the previous grant.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic      if_req,
    input  logic      d_req,
    input  arb_port_e last_gnt,
    output logic      gnt_valid,
    output arb_port_e gnt_port
);

`ifdef MEM_ARB_RR_EN
    // Single requester always wins; on a tie alternate away from last_gnt.
    always_comb begin
        gnt_valid = if_req | d_req;
        gnt_port  = ARB_PORT_D;
        if (if_req && !d_req) begin
            gnt_port = ARB_PORT_IF;
        end else if (if_req && d_req && (last_gnt == ARB_PORT_D)) begin
            gnt_port = ARB_PORT_IF;
        end
    end
`else
    // Fixed priority: data beats fetch; history is tracked but not consulted.
    always_comb begin
        gnt_valid = if_req | d_req;
        gnt_port  = ARB_PORT_D;
        if (if_req && !d_req) begin
            gnt_port = ARB_PORT_IF;
        end
    end

    logic unused_last_gnt;
    assign unused_last_gnt = ^last_gnt;
`endif

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// A granted request is latched, strobed to memory for one cycle, then the
// arbiter waits MEM_LAT cycles, captures read data and pulses *_done.
// Optional MEM_ARB_RR_EN selects alternating grants on ties (see mem_arb_pick).
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Reject latencies the wait counter cannot represent.
    if (!lat_legal(MEM_LAT)) begin : g_bad_lat
        $error("mem_arb: MEM_LAT must be in 1..15");
    end

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

    arb_state_e       state_q,    state_d;
    arb_port_e        last_gnt_q, last_gnt_d;
    arb_port_e        port_q,     port_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             we_q,       we_d;
    logic [AW-1:0]    addr_q,     addr_d;
    logic [DW-1:0]    wdata_q,    wdata_d;
    logic             mem_en_q,   mem_en_d;
    logic             mem_we_q,   mem_we_d;
    logic             if_done_q,  if_done_d;
    logic             d_done_q,   d_done_d;
    logic [DW-1:0]    if_rdata_q, if_rdata_d;
    logic [DW-1:0]    d_rdata_q,  d_rdata_d;

    logic             gnt_valid;
    arb_port_e        gnt_port;
    logic             cnt_last;

    assign cnt_last = (cnt_q == CNT_W'(1));

    mem_arb_pick u_pick (
        .if_req    (if_req),
        .d_req     (d_req),
        .last_gnt  (last_gnt_q),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (gnt_valid) state_d = ARB_ACCESS;
            ARB_ACCESS: state_d = ARB_WAIT;
            ARB_WAIT:   if (cnt_last) state_d = ARB_DONE;
            ARB_DONE:   state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    // Datapath and output next values for each state.
    always_comb begin
        last_gnt_d = last_gnt_q;
        port_d     = port_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    port_d     = gnt_port;
                    last_gnt_d = gnt_port;
                    mem_en_d   = 1'b1;
                    if (gnt_port == ARB_PORT_D) begin
                        we_d     = d_we;
                        addr_d   = d_addr;
                        wdata_d  = d_wdata;
                        mem_we_d = d_we;
                    end else begin
                        we_d     = 1'b0;
                        addr_d   = if_addr;
                        wdata_d  = '0;
                        mem_we_d = 1'b0;
                    end
                end
            end
            ARB_ACCESS: begin
                cnt_d = LAT_INIT;
            end
            ARB_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_last) begin
                    if (port_q == ARB_PORT_D) begin
                        d_done_d = 1'b1;
                        if (!we_q) d_rdata_d = mem_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            ARB_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Latched request, memory strobes, done pulses and read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_q <= ARB_PORT_D;
            port_q     <= ARB_PORT_D;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            port_q     <= port_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    // Core freezes while its own request is outstanding.
    assign if_stall = if_req & ~if_done_q;
    assign d_stall  = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: two lanes (MEM_LAT=1 and MEM_LAT=3), each with a memory
// model, directed scenarios, random requesters and a transaction-timeline
// reference model checked every cycle.
module tb_mem_arb;

    int n_checks = 0;
    int n_errors = 0;
    logic clk = 1'b0;
    bit   lane_done [2];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Power-on memory contents; word 1 holds the known fetch pattern.
    function automatic logic [31:0] init_word(input int idx);
        if (idx == 1) return 32'h2402_0005;
        return (32'(idx) * 32'h0001_0103) ^ 32'h5A5A_0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned LAT = (g == 0) ? 1 : 3;

        logic        rst;
        logic        if_req, d_req, d_we;
        logic [31:0] if_addr, d_addr, d_wdata;
        logic        if_done, if_stall, d_done, d_stall;
        logic [31:0] if_rdata, d_rdata;
        logic        mem_en, mem_we;
        logic [31:0] mem_addr, mem_wdata, mem_rdata;
        bit          chk_on = 1'b0;
        string       pfx;

        mem_arb #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_done   (if_done),
            .if_rdata  (if_rdata),
            .if_stall  (if_stall),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_done    (d_done),
            .d_rdata   (d_rdata),
            .d_stall   (d_stall),
            .mem_en    (mem_en),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata)
        );

        // Memory: read data appears LAT cycles after the strobe edge, for one cycle.
        logic [31:0] ram [256];
        bit          ram_vld [256];
        logic [31:0] pipe [LAT];
        assign mem_rdata = pipe[LAT-1];

        always @(posedge clk) begin
            for (int k = LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            if (mem_en) begin
                pipe[0] <= ram_vld[mem_addr[9:2]] ? ram[mem_addr[9:2]] : init_word(int'(mem_addr[9:2]));
                if (mem_we) begin
                    ram[mem_addr[9:2]]     <= mem_wdata;
                    ram_vld[mem_addr[9:2]] <= 1'b1;
                end
            end else begin
                pipe[0] <= 32'hBAD0_BAD0;
            end
        end

        // Reference model: each grant defines a timeline relative to its sample edge.
        bit          active = 1'b0;
        bit          last_d = 1'b1;
        int          age;
        bit          m_d, m_we;
        logic [31:0] m_addr, m_data;
        logic [31:0] ref_mem [256];
        bit          ref_vld [256];
        logic        exp_mem_en, exp_mem_we, exp_if_done, exp_d_done;
        logic [31:0] exp_mem_addr, exp_mem_wdata, exp_if_rdata, exp_d_rdata;

        always @(posedge clk) begin
            if (!rst) begin
                active = 1'b0;
                last_d = 1'b1;
                exp_mem_en = 1'b0; exp_mem_we = 1'b0;
                exp_if_done = 1'b0; exp_d_done = 1'b0;
                exp_mem_addr = '0; exp_mem_wdata = '0;
                exp_if_rdata = '0; exp_d_rdata = '0;
            end else begin
                exp_mem_en  = 1'b0;
                exp_if_done = 1'b0;
                exp_d_done  = 1'b0;
                if (active) begin
                    age++;
                    if (age == int'(LAT) + 1) begin
                        if (m_d) exp_d_done = 1'b1; else exp_if_done = 1'b1;
                        if (!m_we) begin
                            if (m_d) exp_d_rdata = m_data; else exp_if_rdata = m_data;
                        end
                    end else if (age == int'(LAT) + 2) begin
                        active = 1'b0;
                    end
                end else if (if_req || d_req) begin
                    if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                        m_d = !last_d;
`else
                        m_d = 1'b1;
`endif
                    end else begin
                        m_d = d_req;
                    end
                    last_d = m_d;
                    active = 1'b1;
                    age    = 0;
                    m_we   = m_d && d_we;
                    m_addr = m_d ? d_addr : if_addr;
                    m_data = ref_vld[m_addr[9:2]] ? ref_mem[m_addr[9:2]] : init_word(int'(m_addr[9:2]));
                    if (m_we) begin
                        ref_mem[m_addr[9:2]] = d_wdata;
                        ref_vld[m_addr[9:2]] = 1'b1;
                    end
                    exp_mem_en    = 1'b1;
                    exp_mem_we    = m_we;
                    exp_mem_addr  = m_addr;
                    exp_mem_wdata = d_wdata;
                end
            end
        end

        // Compare every output mid-cycle against the model (all zero in reset).
        always @(negedge clk) begin
            if (chk_on) begin
                if (!rst) begin
                    check({pfx, " rst mem_en"}, 32'(mem_en), 32'd0);
                    check({pfx, " rst mem_we"}, 32'(mem_we), 32'd0);
                    check({pfx, " rst mem_addr"}, mem_addr, 32'd0);
                    check({pfx, " rst mem_wdata"}, mem_wdata, 32'd0);
                    check({pfx, " rst if_done"}, 32'(if_done), 32'd0);
                    check({pfx, " rst d_done"}, 32'(d_done), 32'd0);
                    check({pfx, " rst if_rdata"}, if_rdata, 32'd0);
                    check({pfx, " rst d_rdata"}, d_rdata, 32'd0);
                end else begin
                    check({pfx, " mem_en"}, 32'(mem_en), 32'(exp_mem_en));
                    if (exp_mem_en) begin
                        check({pfx, " mem_we"}, 32'(mem_we), 32'(exp_mem_we));
                        if (exp_mem_we) check({pfx, " mem_wdata"}, mem_wdata, exp_mem_wdata);
                    end
                    if (active) check({pfx, " mem_addr"}, mem_addr, exp_mem_addr);
                    check({pfx, " if_done"}, 32'(if_done), 32'(exp_if_done));
                    check({pfx, " d_done"}, 32'(d_done), 32'(exp_d_done));
                    check({pfx, " if_rdata"}, if_rdata, exp_if_rdata);
                    check({pfx, " d_rdata"}, d_rdata, exp_d_rdata);
                end
                check({pfx, " if_stall"}, 32'(if_stall), 32'(if_req & ~(rst & exp_if_done)));
                check({pfx, " d_stall"}, 32'(d_stall), 32'(d_req & ~(rst & exp_d_done)));
            end
        end

        // Wait (bounded) for the fetch done pulse, then drop the request.
        task automatic if_wait(output int n);
            n = 0;
            for (int k = 0; k < 400; k++) begin
                @(posedge clk); #1;
                n++;
                if (if_done) begin
                    if_req = 1'b0;
                    return;
                end
            end
            check({pfx, " if_timeout"}, 32'(if_done), 32'd1);
            if_req = 1'b0;
        endtask

        task automatic d_wait(output int n);
            n = 0;
            for (int k = 0; k < 400; k++) begin
                @(posedge clk); #1;
                n++;
                if (d_done) begin
                    d_req = 1'b0;
                    return;
                end
            end
            check({pfx, " d_timeout"}, 32'(d_done), 32'd1);
            d_req = 1'b0;
        endtask

        task automatic idle(input int cyc);
            repeat (cyc) begin
                @(posedge clk); #1;
            end
        endtask

        task automatic rand_if();
            int n;
            repeat (60) begin
                idle(int'($urandom_range(0, 3)));
                if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                if_req  = 1'b1;
                if_wait(n);
            end
        endtask

        task automatic rand_d();
            int n;
            repeat (60) begin
                idle(int'($urandom_range(0, 5)));
                d_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                d_we    = 1'($urandom_range(0, 1));
                d_wdata = $urandom;
                d_req   = 1'b1;
                d_wait(n);
            end
        endtask

        initial begin
            int ni, nd, n;
            logic [31:0] saved;
            pfx = $sformatf("L%0d", LAT);
            rst = 1'b0;
            if_req = 1'b1; if_addr = 32'h100;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104; d_wdata = 32'd0;
            repeat (2) @(posedge clk);
            #1 chk_on = 1'b1;
            idle(3);
            rst = 1'b1;

            // Both requests held through reset: exactly one winner first.
            fork
                begin if_wait(ni); end
                begin d_wait(nd); end
            join
`ifdef MEM_ARB_RR_EN
            check({pfx, " first_if_lat"}, 32'(ni), 32'(LAT + 2));
            check({pfx, " second_d_lat"}, 32'(nd), 32'(2 * LAT + 5));
`else
            check({pfx, " first_d_lat"}, 32'(nd), 32'(LAT + 2));
            check({pfx, " second_if_lat"}, 32'(ni), 32'(2 * LAT + 5));
`endif
            check({pfx, " first_d_rdata"}, d_rdata, init_word(65));

            // Single fetch of the known word.
            idle(1);
            if_addr = 32'h4; if_req = 1'b1;
            if_wait(n);
            check({pfx, " fetch_lat"}, 32'(n), 32'(LAT + 2));
            check({pfx, " fetch_rdata"}, if_rdata, 32'h2402_0005);

            // Store then load back.
            idle(1);
            saved = d_rdata;
            d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
            d_wait(n);
            check({pfx, " store_lat"}, 32'(n), 32'(LAT + 2));
            check({pfx, " store_keeps_rdata"}, d_rdata, saved);
            idle(1);
            d_we = 1'b0; d_wdata = 32'd0; d_req = 1'b1;
            d_wait(n);
            check({pfx, " load_lat"}, 32'(n), 32'(LAT + 2));
            check({pfx, " load_rdata"}, d_rdata, 32'hDEAD_BEEF);

            // Contention after a data grant.
            idle(1);
            if_addr = 32'h8; d_addr = 32'h10; d_we = 1'b0;
            if_req = 1'b1; d_req = 1'b1;
            fork
                begin if_wait(ni); end
                begin d_wait(nd); end
            join
`ifdef MEM_ARB_RR_EN
            check({pfx, " rr_if_lat"}, 32'(ni), 32'(LAT + 2));
            check({pfx, " rr_d_lat"}, 32'(nd), 32'(2 * LAT + 5));
`else
            check({pfx, " prio_d_lat"}, 32'(nd), 32'(LAT + 2));
            check({pfx, " prio_if_lat"}, 32'(ni), 32'(2 * LAT + 5));
`endif
            check({pfx, " cont_if_rdata"}, if_rdata, init_word(2));

            // Reset during WAIT aborts; the held request is re-served.
            idle(1);
            d_addr = 32'h30; d_we = 1'b0; d_req = 1'b1;
            idle(2);
            rst = 1'b0;
            idle(2);
            rst = 1'b1;
            d_wait(n);
            check({pfx, " rst_reserve_lat"}, 32'(n), 32'(LAT + 2));
            check({pfx, " rst_reserve_rdata"}, d_rdata, init_word(12));

            // Address change after grant is ignored.
            idle(1);
            d_addr = 32'h20; d_we = 1'b0; d_req = 1'b1;
            fork
                begin d_wait(n); end
                begin idle(2); d_addr = 32'h40; end
            join
            check({pfx, " latched_addr_rdata"}, d_rdata, init_word(8));

            // Random traffic on both ports.
            idle(1);
            fork
                rand_if();
                rand_d();
            join
            idle(3);
            lane_done[g] = 1'b1;
        end
    end

    initial begin
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk);
            if (lane_done[0] && lane_done[1]) break;
        end
        if (!(lane_done[0] && lane_done[1]))
            check("lanes_finished", 32'(lane_done[0] & lane_done[1]), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
